// File: rtl/seq_mult_datapath.sv
// Shift-add multiplier datapath steered by an external load/iterate/capture controller.
// Define SIGNED_MULT_EN for two's-complement operands (sign-magnitude multiply with final negation).
module seq_mult_datapath #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s,
    input  logic                 en1,
    input  logic                 en2,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 not64,
    output logic [2*WIDTH-1:0]   product,
    output logic                 prod_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] aReg_q, aReg_d;
    logic [WIDTH-1:0]   bReg_q, bReg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [2*WIDTH-1:0] finalVal;

    wire loadCycle = en1 && !s;

`ifdef SIGNED_MULT_EN
    logic neg_q;

    // Negating -2^(W-1) gives the same bit pattern, which read unsigned is exactly its magnitude.
    assign aMag     = a[WIDTH-1] ? -a : a;
    assign bMag     = b[WIDTH-1] ? -b : b;
    assign finalVal = neg_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else if (loadCycle) begin
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign aMag     = a;
    assign bMag     = b;
    assign finalVal = acc_q;
`endif

    // Clearing prod_valid on a load overrides a simultaneous capture.
    always_comb begin
        aReg_d    = aReg_q;
        bReg_d    = bReg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        valid_d   = valid_q;
        if (en1) begin
            if (!s) begin
                aReg_d = {{WIDTH{1'b0}}, aMag};
                bReg_d = bMag;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d  = acc_q + (bReg_q[0] ? aReg_q : '0);
                aReg_d = aReg_q << 1;
                bReg_d = bReg_q >> 1;
                cnt_d  = (cnt_q == LastCnt) ? '0 : cnt_q + CW'(1);
            end
        end
        if (en2) begin
            product_d = finalVal;
            valid_d   = 1'b1;
        end
        if (loadCycle) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aReg_q    <= '0;
            bReg_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            aReg_q    <= aReg_d;
            bReg_q    <= bReg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign not64      = (cnt_q != LastCnt);
    assign product    = product_q;
    assign prod_valid = valid_q;

endmodule

// File: tb/tb_seq_mult_datapath.sv
// Bench for seq_mult_datapath: emulates the controller sequence and checks products against hand-computed values.
// Honours SIGNED_MULT_EN the same way the design does.
module tb_seq_mult_datapath;

    localparam int W = 64;
    localparam int IterBudget = 200;

    logic           clk = 1'b0;
    logic           reset;
    logic           s, en1, en2;
    logic [W-1:0]   a, b;
    logic           not64;
    logic [2*W-1:0] product;
    logic           prod_valid;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [W-1:0]   opA;
        logic [W-1:0]   opB;
        logic [2*W-1:0] expProd;
    } vec_t;

    vec_t vecs [6];

    seq_mult_datapath #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .en1       (en1),
        .en2       (en2),
        .a         (a),
        .b         (b),
        .not64     (not64),
        .product   (product),
        .prod_valid(prod_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One load cycle; operands are then scrambled to show they are only sampled here.
    task automatic loadOperands(input logic [W-1:0] aIn, input logic [W-1:0] bIn, input logic capture);
        s   = 1'b0;
        en1 = 1'b1;
        en2 = capture;
        a   = aIn;
        b   = bIn;
        @(negedge clk);
        en1 = 1'b0;
        en2 = 1'b0;
        a   = ~aIn;
        b   = ~bIn;
    endtask

    // Iterates until not64 drops (optionally freezing en1 for a while), then captures.
    task automatic applyStimulus(input string name, input logic [127:0] expProd,
                                 input int pauseAt, input int pauseLen);
        int   iter;
        logic lastNot;
        iter = 0;
        s    = 1'b1;
        en1  = 1'b1;
        do begin
            if (iter == pauseAt) begin
                en1 = 1'b0;
                repeat (pauseLen) begin
                    @(negedge clk);
                    checkOutput({name, " frozen not64"}, 128'(not64), 128'd1);
                end
                en1 = 1'b1;
            end
            lastNot = not64;
            iter++;
            a = W'({$urandom, $urandom});
            b = W'({$urandom, $urandom});
            @(negedge clk);
        end while (lastNot && iter < IterBudget);
        en1 = 1'b0;
        s   = 1'b0;
        checkOutput({name, " iterations"}, 128'(iter), 128'(W));
        checkOutput({name, " valid before capture"}, 128'(prod_valid), 128'd0);
        en2 = 1'b1;
        @(negedge clk);
        en2 = 1'b0;
        checkOutput({name, " product"}, product, expProd);
        checkOutput({name, " valid"}, 128'(prod_valid), 128'd1);
    endtask

    initial begin
`ifdef SIGNED_MULT_EN
        vecs[0] = '{64'd3, 64'd5, 128'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, -128'd15};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 128'h8000_0000_0000_0000};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};
        vecs[4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 128'd0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF7, 128'd63};
`else
        vecs[0] = '{64'd3, 64'd5, 128'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0};
        vecs[3] = '{64'hDEAD_BEEF, 64'd0, 128'd0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
        vecs[5] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001};
`endif

        reset = 1'b0;
        s     = 1'b0;
        en1   = 1'b0;
        en2   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset product", product, 128'd0);
        checkOutput("reset valid", 128'(prod_valid), 128'd0);
        checkOutput("reset not64", 128'(not64), 128'd1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            loadOperands(vecs[i].opA, vecs[i].opB, 1'b0);
            applyStimulus($sformatf("vec%0d", i), vecs[i].expProd, -1, 0);
        end

        // Repeated capture with en1 low must not disturb the result.
        en2 = 1'b1;
        repeat (3) @(negedge clk);
        en2 = 1'b0;
        checkOutput("repeat capture product", product, vecs[5].expProd);
        checkOutput("repeat capture valid", 128'(prod_valid), 128'd1);

        loadOperands(64'd7, 64'd9, 1'b0);
        applyStimulus("freeze", 128'd63, 20, 5);

        loadOperands(64'd3, 64'd5, 1'b1);
        checkOutput("load+capture valid", 128'(prod_valid), 128'd0);
        applyStimulus("after load+capture", 128'd15, -1, 0);

        // Asynchronous reset in the middle of a run, applied and checked during the low clock phase.
        loadOperands(64'd7, 64'd9, 1'b0);
        s   = 1'b1;
        en1 = 1'b1;
        repeat (10) @(negedge clk);
        en1 = 1'b0;
        s   = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("midrun reset product", product, 128'd0);
        checkOutput("midrun reset valid", 128'(prod_valid), 128'd0);
        checkOutput("midrun reset not64", 128'(not64), 128'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        loadOperands(64'd3, 64'd5, 1'b0);
        applyStimulus("after reset", 128'd15, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
